memmap_bus_sched: RTL and testbench
===================================

// Module: memmap_bus_sched
// PURPOSE
//  Two-master scheduler for the 16-bit memory-mapped decode bus (AS/AH/AL) feeding the PREP9-style address mapper.
//  Arbitrates round-robin between two requesters and runs one strobe cycle per transaction.
//  Inserts region-dependent wait states, then returns a one-cycle ACK to the granted master.
//  Sits between the bus masters and the mapper; the mapper's BE and H..A outputs are not routed through this block.
// PARAMETERS
//  WS_LO   4'd0  wait states, addr 0000..E2AA (BE region)
//  WS_IO   4'd2  wait states, addr E2AB..E2FF
//  WS_MID  4'd1  wait states, addr E300..EFFF
//  WS_TOP  4'd3  wait states, addr F000..FFFF
// PORTS
//  CLK    in   1   clock, all state on rising edge
//  RST    in   1   asynchronous reset, active-low
//  REQ0   in   1   master 0 request, held until ACK0
//  ADDR0  in   16  master 0 address, stable while REQ0=1
//  REQ1   in   1   master 1 request, held until ACK1
//  ADDR1  in   16  master 1 address, stable while REQ1=1
//  GNT0   out  1   master 0 owns bus (grant cycle through ACK cycle)
//  GNT1   out  1   master 1 owns bus
//  ACK0   out  1   one-cycle completion pulse, master 0
//  ACK1   out  1   one-cycle completion pulse, master 1
//  AS     out  1   address strobe to mapper, one cycle per transaction
//  AH     out  8   address bits [15:8] to mapper
//  AL     out  8   address bits [7:0] to mapper
//  BUSY   out  1   state != IDLE
// BEHAVIOUR
//  All outputs registered. RST=0 (async): state IDLE; GNT*, ACK*, AS, BUSY=0; AH/AL=0; LAST=1 (master 0 wins first tie).
//  FSM: IDLE -> STROBE -> WAIT -> DONE -> IDLE.
//  IDLE:
//   - Sample REQ0/REQ1. Only one high: grant it. Both high: grant the master != LAST.
//   - On grant: latch ADDRx into ADDR_Q, set GNTx, load WCNT from the region of ADDRx, LAST<=x, go STROBE.
//  STROBE (1 cycle): AS=1, {AH,AL}=ADDR_Q. Next state: WCNT==0 -> DONE, else WAIT.
//  WAIT: AS=0, {AH,AL} hold ADDR_Q, WCNT decrements each cycle. Go DONE in the cycle WCNT==1 (exactly WCNT cycles in WAIT).
//  DONE (1 cycle): ACKx=1 for the owner, GNTx still 1. Next cycle: GNT*=0, AH/AL=0, IDLE.
//  Latency: REQ seen at edge N -> GNT at N+1, AS at N+1, ACK at N+2+WS, next grant earliest N+4+WS.
//   - Back-to-back transactions therefore have one IDLE cycle between them.
//  Region decode uses unsigned 16-bit compares with inclusive upper bounds: E2AA, E2FF, EFFF. FFFF maps to WS_TOP.
//  Invariants: GNT0 & GNT1 never both 1; ACK only asserted with the matching GNT; AS only in STROBE.
//  REQ dropped or ADDR changed mid-transaction: ignored; the transaction completes from ADDR_Q and ACK still pulses.
//  REQ of the non-owner during a transaction: held pending, arbitrated on return to IDLE.
//  A master that keeps REQ high after its ACK is re-arbitrated in IDLE; round-robin guarantees alternation under contention.
//  RST low mid-transaction: immediate abort, all outputs 0, no ACK; after release, arbitration restarts with LAST=1.
// TESTING
//  T1 reset release, REQ0=1 ADDR0=E2AA at edge N -> GNT0 N+1, AS=1 {AH,AL}=E2AA at N+1 only, ACK0 at N+2, GNT0 low N+3.
//  T2 ADDR0=E2AB -> ACK0 at N+4 (WS_IO=2). ADDR0=F000 -> ACK0 at N+5. ADDR0=E300 -> ACK0 at N+3.
//  T3 REQ0=REQ1=1 held after reset (ADDR0=1000, ADDR1=FFFF) -> grants 0,1,0,1...; GNTs never overlap; AS carries 1000, then FFFF.
//  T4 REQ1 rises while master 0 is in WAIT -> GNT1 two cycles after ACK0 (one IDLE cycle between).
//  T5 REQ0 dropped and ADDR0 changed during WAIT -> ACK0 still pulses at the scheduled cycle; AH/AL hold the original address.
//  T6 RST low during WAIT of an F000 access -> outputs 0 the same cycle, no ACK; after release with both requesting, master 0 is granted.

Source files
------------

// File: rtl/memmap_bus_sched_if.sv
// rtl/memmap_bus_sched_if.sv - request/grant/strobe bus between masters, scheduler and address mapper
interface memmap_bus_sched_if;
    logic        req0;
    logic [15:0] addr0;
    logic        req1;
    logic [15:0] addr1;
    logic        gnt0;
    logic        gnt1;
    logic        ack0;
    logic        ack1;
    logic        as;
    logic [7:0]  ah;
    logic [7:0]  al;
    logic        busy;

    modport master (
        output req0, addr0, req1, addr1,
        input  gnt0, gnt1, ack0, ack1, as, ah, al, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output gnt0, gnt1, ack0, ack1, as, ah, al, busy
    );
endinterface

// File: rtl/memmap_bus_sched.sv
// rtl/memmap_bus_sched.sv - two-master round-robin scheduler with region wait states for the mapper bus
module memmap_bus_sched #(
    parameter logic [3:0] WS_LO  = 4'd0,
    parameter logic [3:0] WS_IO  = 4'd2,
    parameter logic [3:0] WS_MID = 4'd1,
    parameter logic [3:0] WS_TOP = 4'd3
) (
    input  logic                clk,
    input  logic                rst,
    memmap_bus_sched_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    state_t      state, state_n;
    logic        last, last_n;
    logic        owner, owner_n;
    logic [15:0] addr_q, addr_q_n;
    logic [3:0]  wcnt, wcnt_n;
    logic        pick;
    logic        gnt0_n, gnt1_n, ack0_n, ack1_n, as_n, busy_n;
    logic [7:0]  ah_n, al_n;

    // Upper bounds are inclusive; anything above EFFF falls into the top region.
    function automatic logic [3:0] region_ws(input logic [15:0] a);
        if (a <= 16'hE2AA)      return WS_LO;
        else if (a <= 16'hE2FF) return WS_IO;
        else if (a <= 16'hEFFF) return WS_MID;
        else                    return WS_TOP;
    endfunction

    always_comb begin
        state_n  = state;
        last_n   = last;
        owner_n  = owner;
        addr_q_n = addr_q;
        wcnt_n   = wcnt;
        pick     = 1'b0;
        gnt0_n   = bus.gnt0;
        gnt1_n   = bus.gnt1;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        as_n     = 1'b0;
        ah_n     = bus.ah;
        al_n     = bus.al;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    pick            = (bus.req0 && bus.req1) ? ~last : bus.req1;
                    owner_n         = pick;
                    last_n          = pick;
                    addr_q_n        = pick ? bus.addr1 : bus.addr0;
                    wcnt_n          = region_ws(addr_q_n);
                    gnt0_n          = ~pick;
                    gnt1_n          = pick;
                    as_n            = 1'b1;
                    {ah_n, al_n}    = addr_q_n;
                    state_n         = STROBE;
                end
            end
            STROBE: begin
                if (wcnt == 4'd0) begin
                    state_n = DONE;
                    ack0_n  = ~owner;
                    ack1_n  = owner;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                wcnt_n = wcnt - 4'd1;
                if (wcnt <= 4'd1) begin
                    state_n = DONE;
                    ack0_n  = ~owner;
                    ack1_n  = owner;
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
                ah_n    = 8'h00;
                al_n    = 8'h00;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            addr_q   <= 16'h0000;
            wcnt     <= 4'd0;
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.as   <= 1'b0;
            bus.ah   <= 8'h00;
            bus.al   <= 8'h00;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            owner    <= owner_n;
            addr_q   <= addr_q_n;
            wcnt     <= wcnt_n;
            bus.gnt0 <= gnt0_n;
            bus.gnt1 <= gnt1_n;
            bus.ack0 <= ack0_n;
            bus.ack1 <= ack1_n;
            bus.as   <= as_n;
            bus.ah   <= ah_n;
            bus.al   <= al_n;
            bus.busy <= busy_n;
        end
    end

endmodule

// File: tb/tb_memmap_bus_sched.sv
// tb/tb_memmap_bus_sched.sv - directed and randomized bench for memmap_bus_sched against a transaction timeline model
module tb_memmap_bus_sched;

    logic clk = 1'b0;
    logic rst;

    memmap_bus_sched_if bus ();

    memmap_bus_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: each transaction is a window of edges [t_g, t_g+1+ws], next arbitration at t_g+3+ws.
    int          edge_n = 0;
    int          free_e = 0;
    int          t_g    = -100;
    int          ws_m   = 0;
    bit          last_m = 1'b1;
    bit          own_m  = 1'b0;
    logic [15:0] a_m    = 16'h0000;

    logic [15:0] bnd [8] = '{16'h0000, 16'hE2AA, 16'hE2AB, 16'hE2FF,
                             16'hE300, 16'hEFFF, 16'hF000, 16'hFFFF};

    function automatic int ws_of(input logic [15:0] a);
        if (a < 16'hE2AB) return 0;
        if (a < 16'hE300) return 2;
        if (a < 16'hF000) return 1;
        return 3;
    endfunction

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return bnd[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit win, input bit ack);
        chk({tag, ".gnt0"}, 16'(bus.gnt0), 16'(win && !own_m));
        chk({tag, ".gnt1"}, 16'(bus.gnt1), 16'(win && own_m));
        chk({tag, ".ack0"}, 16'(bus.ack0), 16'(ack && !own_m));
        chk({tag, ".ack1"}, 16'(bus.ack1), 16'(ack && own_m));
        chk({tag, ".as"},   16'(bus.as),   16'(win && edge_n == t_g));
        chk({tag, ".ahal"}, {bus.ah, bus.al}, win ? a_m : 16'h0000);
        chk({tag, ".busy"}, 16'(bus.busy), 16'(win));
    endtask

    task automatic step(input string tag);
        bit r0, r1, rs, win;
        logic [15:0] x0, x1;
        int done_e;
        r0 = bus.req0; r1 = bus.req1; x0 = bus.addr0; x1 = bus.addr1; rs = rst;
        @(posedge clk);
        edge_n++;
        if (rs && edge_n >= free_e && (r0 || r1)) begin
            own_m  = (r0 && r1) ? !last_m : r1;
            a_m    = own_m ? x1 : x0;
            ws_m   = ws_of(a_m);
            t_g    = edge_n;
            free_e = edge_n + 3 + ws_m;
            last_m = own_m;
        end
        done_e = t_g + 1 + ws_m;
        win    = (edge_n >= t_g) && (edge_n <= done_e);
        #1;
        chk_all(tag, win, edge_n == done_e);
    endtask

    // mode 0: drop request on ACK; 1: hold request; 2: random master behaviour
    task automatic react(input int mode);
        if (bus.ack0) begin
            bus.req0 = (mode == 1) || (mode == 2 && $urandom_range(0, 3) == 0);
            if (mode == 2 && bus.req0) bus.addr0 = rand_addr();
        end else if (mode == 2 && !bus.req0 && $urandom_range(0, 1) == 1) begin
            bus.req0 = 1'b1; bus.addr0 = rand_addr();
        end else if (mode == 2 && bus.gnt0 && $urandom_range(0, 7) == 0) begin
            bus.req0 = 1'($urandom_range(0, 1)); bus.addr0 = rand_addr();
        end
        if (bus.ack1) begin
            bus.req1 = (mode == 1) || (mode == 2 && $urandom_range(0, 3) == 0);
            if (mode == 2 && bus.req1) bus.addr1 = rand_addr();
        end else if (mode == 2 && !bus.req1 && $urandom_range(0, 1) == 1) begin
            bus.req1 = 1'b1; bus.addr1 = rand_addr();
        end else if (mode == 2 && bus.gnt1 && $urandom_range(0, 7) == 0) begin
            bus.req1 = 1'($urandom_range(0, 1)); bus.addr1 = rand_addr();
        end
    endtask

    task automatic run(input string tag, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            step(tag);
            react(mode);
        end
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #1;
        t_g    = -100;
        last_m = 1'b1;
        free_e = 0;
        chk_all({tag, ".async"}, 1'b0, 1'b0);
        step({tag, ".held"});
        step({tag, ".held"});
    endtask

    initial begin
        rst = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = 16'h0000; bus.addr1 = 16'h0000;
        @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0);
        step("reset");
        rst = 1'b1;

        bus.req0 = 1'b1; bus.addr0 = 16'hE2AA;
        run("t1", 5, 0);
        bus.req0 = 1'b1; bus.addr0 = 16'hE2AB;
        run("t2_io", 7, 0);
        bus.req0 = 1'b1; bus.addr0 = 16'hF000;
        run("t2_top", 8, 0);
        bus.req0 = 1'b1; bus.addr0 = 16'hE300;
        run("t2_mid", 6, 0);

        bus.req0 = 1'b1; bus.addr0 = 16'h1000; bus.req1 = 1'b1; bus.addr1 = 16'hFFFF;
        run("t3", 24, 1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        run("t3_end", 6, 0);

        bus.req0 = 1'b1; bus.addr0 = 16'hF000;
        run("t4", 2, 0);
        bus.req1 = 1'b1; bus.addr1 = 16'h0042;
        run("t4", 12, 0);

        bus.req0 = 1'b1; bus.addr0 = 16'hE2C0;
        run("t5", 2, 0);
        bus.req0 = 1'b0; bus.addr0 = 16'h1234;
        run("t5", 6, 0);

        bus.req0 = 1'b1; bus.addr0 = 16'hF000;
        run("t6", 2, 0);
        bus.req1 = 1'b1; bus.addr1 = 16'hABCD;
        apply_reset("t6_rst");
        rst = 1'b1;
        step("t6_rel");
        chk("t6_first_gnt0", 16'(bus.gnt0), 16'h0001);
        react(0);
        run("t6", 12, 0);

        for (int i = 0; i < 600; i++) begin
            step("rand");
            react(2);
            if ($urandom_range(0, 149) == 0) begin
                apply_reset("rand_rst");
                rst = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
